// File: rtl/rf_scoreboard.sv
// Issue-side RAW/WAW hazard scoreboard for the integer register file.
// Tracks busy destinations of long-latency writers and bounds outstanding writebacks.
module rf_scoreboard #(
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   iss_valid,
  input  logic [RFIDX_WIDTH-1:0] iss_rs1,
  input  logic                   iss_rs1_used,
  input  logic [RFIDX_WIDTH-1:0] iss_rs2,
  input  logic                   iss_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] iss_rd,
  input  logic                   iss_rd_track,
  output logic                   iss_stall,
  output logic                   iss_fire,
  input  logic                   wb_valid,
  input  logic [RFIDX_WIDTH-1:0] wb_rd,
  input  logic                   flush,
  output logic [RFREG_NUM-1:0]   busy_vec,
  output logic [CNT_W-1:0]       pend_cnt,
  output logic                   wb_err
);

  logic [RFREG_NUM-1:0] busy_r;
  logic [CNT_W-1:0]     pend_r;
  logic                 err_r;

  logic [RFREG_NUM-1:0] wb_dec_s;
  logic [RFREG_NUM-1:0] set_dec_s;
  logic [RFREG_NUM-1:0] clr_dec_s;
  logic [RFREG_NUM-1:0] hit_vec_s;
  logic [RFREG_NUM-1:0] busy_nxt_s;
  logic [CNT_W-1:0]     pend_nxt_s;
  logic                 full_s;
  logic                 rd_nz_s;
  logic                 wb_clr_s;
  logic                 wb_bad_s;
  logic                 set_s;
  logic                 stall_s;
  logic                 fire_s;

  // Writeback decode; a same-cycle writeback masks the hazard since the RF commits on negedge.
  always_comb begin
    wb_dec_s = '0;
    if (wb_valid) begin
      wb_dec_s[wb_rd] = 1'b1;
    end else begin
      wb_dec_s = '0;
    end
  end

  // Hazard detection and issue handshake.
  always_comb begin
    hit_vec_s = busy_r & ~wb_dec_s;
    full_s    = (pend_r == CNT_W'(MAX_PENDING));
    rd_nz_s   = (iss_rd != {RFIDX_WIDTH{1'b0}});
    stall_s   = iss_valid & ((iss_rs1_used & hit_vec_s[iss_rs1]) |
                             (iss_rs2_used & hit_vec_s[iss_rs2]) |
                             (iss_rd_track & hit_vec_s[iss_rd])  |
                             (iss_rd_track & rd_nz_s & full_s & ~wb_valid));
    fire_s    = iss_valid & ~stall_s & ~flush;
    wb_clr_s  = wb_valid & (wb_rd != {RFIDX_WIDTH{1'b0}}) & busy_r[wb_rd];
    wb_bad_s  = wb_valid & ~wb_clr_s & ~flush;
    set_s     = fire_s & iss_rd_track & rd_nz_s;
  end

  // Next busy vector and pending count; set overrides clear on the same index.
  always_comb begin
    set_dec_s  = '0;
    clr_dec_s  = '0;
    pend_nxt_s = pend_r;
    if (set_s) begin
      set_dec_s[iss_rd] = 1'b1;
    end else begin
      set_dec_s = '0;
    end
    if (wb_clr_s) begin
      clr_dec_s[wb_rd] = 1'b1;
    end else begin
      clr_dec_s = '0;
    end
    busy_nxt_s = ((busy_r & ~clr_dec_s) | set_dec_s) & ~{{(RFREG_NUM-1){1'b0}}, 1'b1};
    case ({set_s, wb_clr_s})
      2'b10:   pend_nxt_s = pend_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   pend_nxt_s = pend_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: pend_nxt_s = pend_r;
    endcase
  end

  // State registers; flush drops all tracking but keeps the sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= '0;
      pend_r <= '0;
      err_r  <= 1'b0;
    end else if (flush) begin
      busy_r <= '0;
      pend_r <= '0;
      err_r  <= err_r;
    end else begin
      busy_r <= busy_nxt_s;
      pend_r <= pend_nxt_s;
      err_r  <= err_r | wb_bad_s;
    end
  end

  assign iss_stall = stall_s;
  assign iss_fire  = fire_s;
  assign busy_vec  = busy_r;
  assign pend_cnt  = pend_r;
  assign wb_err    = err_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Table-driven bench for rf_scoreboard with a queue of expected post-edge state.
module tb_rf_scoreboard;

  logic        clk;
  logic        rstn;
  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic        iss_rs1_used;
  logic [4:0]  iss_rs2;
  logic        iss_rs2_used;
  logic [4:0]  iss_rd;
  logic        iss_rd_track;
  logic        iss_stall;
  logic        iss_fire;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_vec;
  logic [2:0]  pend_cnt;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  rf_scoreboard dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs1_used(iss_rs1_used),
    .iss_rs2(iss_rs2), .iss_rs2_used(iss_rs2_used),
    .iss_rd(iss_rd), .iss_rd_track(iss_rd_track),
    .iss_stall(iss_stall), .iss_fire(iss_fire),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        trk;
    logic        wbv;
    logic [4:0]  wbr;
    logic        fl;
    logic        st;
    logic        fi;
    logic [31:0] busy;
    logic [2:0]  pend;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [2:0]  pend;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[24];

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic trk, input logic wbv, input logic [4:0] wbr,
                              input logic fl, input logic st, input logic fi,
                              input logic [31:0] busy, input logic [2:0] pend, input logic err);
    vec_t t;
    t.valid = valid; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.trk = trk; t.wbv = wbv; t.wbr = wbr; t.fl = fl;
    t.st = st; t.fi = fi; t.busy = busy; t.pend = pend; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    exp_t e;
    @(negedge clk);
    iss_valid = t.valid; iss_rs1 = t.rs1; iss_rs1_used = t.u1;
    iss_rs2 = t.rs2; iss_rs2_used = t.u2; iss_rd = t.rd; iss_rd_track = t.trk;
    wb_valid = t.wbv; wb_rd = t.wbr; flush = t.fl;
    #1;
    chk({tag, " stall"}, {31'd0, iss_stall}, {31'd0, t.st});
    chk({tag, " fire"},  {31'd0, iss_fire},  {31'd0, t.fi});
    e.busy = t.busy; e.pend = t.pend; e.err = t.err; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, " busy"}, busy_vec, e.busy);
    chk({e.tag, " pend"}, {29'd0, pend_cnt}, {29'd0, e.pend});
    chk({e.tag, " err"},  {31'd0, wb_err},   {31'd0, e.err});
  endtask

  initial begin
    //            vld rs1  u1  rs2  u2  rd   trk wbv wbr  fl  st  fi  busy          pend err
    vecs[0]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0000_0000, 3'd0, 0);
    vecs[1]  = mk(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0020, 3'd1, 0);
    vecs[2]  = mk(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 32'h0000_0020, 3'd1, 0);
    vecs[3]  = mk(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 32'h0000_0020, 3'd1, 0);
    vecs[4]  = mk(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0, 1, 32'h0000_0000, 3'd0, 0);
    vecs[5]  = mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0080, 3'd1, 0);
    vecs[6]  = mk(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 5'd7, 0, 0, 1, 32'h0000_0080, 3'd1, 0);
    vecs[7]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0, 0, 32'h0000_0000, 3'd0, 0);
    vecs[8]  = mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0002, 3'd1, 0);
    vecs[9]  = mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0006, 3'd2, 0);
    vecs[10] = mk(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'd0, 0, 0, 1, 32'h0000_000E, 3'd3, 0);
    vecs[11] = mk(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 5'd0, 0, 0, 1, 32'h0000_001E, 3'd4, 0);
    vecs[12] = mk(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0, 1, 0, 32'h0000_001E, 3'd4, 0);
    vecs[13] = mk(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 5'd1, 0, 0, 1, 32'h0000_005C, 3'd4, 0);
    vecs[14] = mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 1, 32'h0000_005C, 3'd4, 0);
    vecs[15] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0, 0, 32'h0000_005C, 3'd4, 1);
    vecs[16] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0000_005C, 3'd4, 1);
    vecs[17] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 0, 0, 32'h0000_0058, 3'd3, 1);
    vecs[18] = mk(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 5'd3, 1, 0, 0, 32'h0000_0000, 3'd0, 1);
    vecs[19] = mk(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0400, 3'd1, 1);
    vecs[20] = mk(1, 5'd0, 0, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 32'h0000_0400, 3'd1, 1);
    vecs[21] = mk(1, 5'd10, 0, 5'd10, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'h0000_0400, 3'd1, 1);
    vecs[22] = mk(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 5'd0, 0, 1, 0, 32'h0000_0400, 3'd1, 1);
    vecs[23] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd10, 0, 0, 0, 32'h0000_0000, 3'd0, 1);

    rstn = 1'b0;
    iss_valid = 1'b0; iss_rs1 = 5'd0; iss_rs1_used = 1'b0; iss_rs2 = 5'd0; iss_rs2_used = 1'b0;
    iss_rd = 5'd0; iss_rd_track = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy_vec, 32'h0);
    chk("reset pend", {29'd0, pend_cnt}, 32'h0);
    chk("reset err",  {31'd0, wb_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with busy_vec=0x24.
    step(mk(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0004, 3'd1, 1), "arst_a");
    step(mk(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 1, 32'h0000_0024, 3'd2, 1), "arst_b");
    iss_valid = 1'b0; iss_rd_track = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("arst busy", busy_vec, 32'h0);
    chk("arst pend", {29'd0, pend_cnt}, 32'h0);
    chk("arst err",  {31'd0, wb_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Writeback to x0 is an error and sticks.
    step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 32'h0000_0000, 3'd0, 1), "wb_x0");
    step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h0000_0000, 3'd0, 1), "err_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Issue-side hazard controller for the three-ported integer register file: 2 combinational read ports, 1 write port written on the falling clock edge, x0 hardwired to zero.
- Tracks one busy bit per architectural register for long-latency writers (loads, multi-cycle ALU ops) and stalls decode on RAW/WAW hazards.
- Bounds the number of in-flight writebacks and is cleared on pipeline flush.
- Sits between decode/issue and the writeback stage that drives the register file write port.

Parameters:
- RFIDX_WIDTH, 5, register index width (matches register file address width).
- RFREG_NUM, 32, number of architectural registers.
- MAX_PENDING, 4, maximum outstanding tracked writebacks (1..RFREG_NUM-1).
- CNT_W, $clog2(MAX_PENDING+1), width of the pending counter.

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_rs1  in  RFIDX_WIDTH  source 1 index.
- iss_rs1_used  in  1  source 1 is read.
- iss_rs2  in  RFIDX_WIDTH  source 2 index.
- iss_rs2_used  in  1  source 2 is read.
- iss_rd  in  RFIDX_WIDTH  destination index.
- iss_rd_track  in  1  instruction has a long-latency destination that must be tracked.
- iss_stall  out  1  combinational; hold decode.
- iss_fire  out  1  combinational; iss_valid & ~iss_stall & ~flush.
- wb_valid  in  1  tracked writeback this cycle (same cycle as register file write enable).
- wb_rd  in  RFIDX_WIDTH  writeback destination (same value as register file write address).
- flush  in  1  kill all in-flight tracked ops.
- busy_vec  out  RFREG_NUM  registered busy bits; bit 0 always 0.
- pend_cnt  out  CNT_W  registered count of outstanding tracked ops.
- wb_err  out  1  sticky; writeback to a non-busy register seen.

Behaviour:
Reset:
- rstn low forces busy_vec=0, pend_cnt=0, wb_err=0 immediately, regardless of clk.
- Operation resumes on the first posedge after release.

Hazard qualifier:
- hit(r) = (r!=0) & busy[r] & ~(wb_valid & wb_rd==r).
- A same-cycle writeback releases its hazard because the register file commits on negedge, so the value is visible to the second-half-cycle read.

Stall:
- iss_stall = iss_valid & ( (iss_rs1_used & hit(iss_rs1)) | (iss_rs2_used & hit(iss_rs2)) | (iss_rd_track & hit(iss_rd)) | (iss_rd_track & iss_rd!=0 & pend_cnt==MAX_PENDING & ~wb_valid) ).
- A writeback in the same cycle frees a slot when the counter is full.
- iss_rd_track with iss_rd==0: never stalls on rd, never sets busy, never counts.

Posedge update, priority order:
1. flush: busy_vec<=0, pend_cnt<=0. Issue and writeback this cycle are ignored. iss_fire=0.
2. Clear: if wb_valid & wb_rd!=0 & busy[wb_rd], clear busy[wb_rd].
3. Set: if iss_fire & iss_rd_track & iss_rd!=0, set busy[iss_rd].
   - Set wins over clear on the same index, so the register stays busy.
4. Counter: +1 on a set, -1 on a valid clear; both in one cycle leaves it unchanged.
   - Never wraps: MAX_PENDING is guarded by the stall, 0 is guarded by the clear-only-if-busy rule.

Error handling:
- wb_valid with wb_rd==0, or to a register whose busy bit is 0: no state change, wb_err<=1 (sticky until reset).
- wb_valid during flush is not an error.

Timing:
- Latency: busy visible the cycle after issue; stall release is same-cycle with writeback.
- iss_stall/iss_fire are pure functions of the inputs plus registered state; no path from iss_* to busy within a cycle.

Test Plan:
- Reset: drive rstn=0 mid-run with busy_vec=0x0000_0024 -> busy_vec=0, pend_cnt=0, wb_err=0 without a clock edge.
- RAW: issue rd=5 tracked; next cycle rs1=5 used -> iss_stall=1 until the wb_rd=5 cycle, in which iss_stall=0, iss_fire=1, and busy_vec[5]=0 after the edge.
- WAW plus same-cycle wb: busy[7]=1; issue rd=7 tracked with wb_valid, wb_rd=7 -> iss_fire=1, busy_vec[7] stays 1, pend_cnt unchanged.
- Capacity: issue tracked rd=1,2,3,4 -> pend_cnt=4; fifth issue rd=6 -> stall; add wb_rd=1 the same cycle -> fire, pend_cnt=4, busy_vec=0x5C.
- x0 and error: issue rd=0 tracked -> no stall, busy_vec/pend_cnt unchanged; then wb_rd=9 not busy -> wb_err=1 and stays 1.
- Flush: pend_cnt=3 with issue and wb asserted alongside flush -> iss_fire=0, busy_vec=0, pend_cnt=0, wb_err unchanged.
